// File: rtl/vc_pipe_ctrl_chain_if.sv
// Handshake and per-stage control bundle for vc_pipe_ctrl_chain.
// The master side is the producer/consumer/datapath environment and the slave side
// is the controller.
interface vc_pipe_ctrl_chain_if #(
  parameter int unsigned p_num_stages = 4,
  parameter int unsigned p_cnt_nbits  = 3
);
  logic                    in_val;
  logic                    in_rdy;
  logic                    out_val;
  logic                    out_rdy;
  logic [p_num_stages-1:0] stall_req;
  logic [p_num_stages-1:0] squash_req;
  logic                    flush;
  logic [p_num_stages-1:0] reg_en;
  logic [p_num_stages-1:0] val;
  logic [p_num_stages-1:0] go;
  logic [p_cnt_nbits-1:0]  occupancy;

  modport master (
    output in_val, out_rdy, stall_req, squash_req, flush,
    input  in_rdy, out_val, reg_en, val, go, occupancy
  );

  modport slave (
    input  in_val, out_rdy, stall_req, squash_req, flush,
    output in_rdy, out_val, reg_en, val, go, occupancy
  );
endinterface

// File: rtl/vc_pipe_ctrl_chain.sv
// Centralised valid/stall/squash control for a linear pipeline.
// Stage 0 is the youngest stage and stage N-1 is the oldest.
// A squash fires only once per resident message, a global flush is provided, and the
// controller keeps a count of the valid stages.
module vc_pipe_ctrl_chain #(
  parameter int unsigned p_num_stages = 4,
  parameter int unsigned p_cnt_nbits  = 3
) (
  input logic                 clk,
  input logic                 reset,
  vc_pipe_ctrl_chain_if.slave bus
);

  logic [p_num_stages-1:0] val_q, val_d;
  logic [p_num_stages-1:0] sq_done_q, sq_done_d;
  logic [p_cnt_nbits-1:0]  occ_q, occ_d;

  logic [p_num_stages-1:0] cs, kill, st, go_raw;
  logic [p_num_stages:0]   sout;
  logic                    cs_any;
  logic                    in_rdy_raw;
  logic                    accept;

  // Kill and stall ripple, computed from the oldest stage towards the youngest.
  always_comb begin
    cs     = val_q & bus.squash_req & ~sq_done_q;
    st     = val_q & bus.stall_req;
    kill   = '0;
    cs_any = 1'b0;
    for (int i = int'(p_num_stages) - 1; i >= 0; i--) begin
      kill[i] = bus.flush | cs_any;  // only squashes from older stages
      cs_any  = cs_any | cs[i];
    end
    sout               = '0;
    sout[p_num_stages] = ~bus.out_rdy;
    go_raw             = '0;
    for (int i = int'(p_num_stages) - 1; i >= 0; i--) begin
      sout[i]   = val_q[i] & ~kill[i] & (st[i] | sout[i+1]);
      go_raw[i] = val_q[i] & ~kill[i] & ~st[i] & ~sout[i+1];
    end
    in_rdy_raw = ~sout[0] & ~bus.flush & ~cs_any;
    accept     = in_rdy_raw & bus.in_val;
  end

  // Next valid bits, squash one-shot flags and occupancy.
  always_comb begin
    val_d    = val_q;
    val_d[0] = sout[0] ? val_q[0] : accept;
    for (int i = 1; i < int'(p_num_stages); i++) begin
      val_d[i] = sout[i] ? val_q[i] : go_raw[i-1];
    end
    // The flag survives only while the message is held in place.
    sq_done_d = sout[p_num_stages-1:0] & (sq_done_q | cs);
    occ_d     = '0;
    for (int i = 0; i < int'(p_num_stages); i++) begin
      occ_d = occ_d + p_cnt_nbits'(val_d[i]);
    end
  end

  // State registers with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q     <= '0;
      sq_done_q <= '0;
      occ_q     <= '0;
    end else begin
      val_q     <= val_d;
      sq_done_q <= sq_done_d;
      occ_q     <= occ_d;
    end
  end

  // Outputs are forced to their idle values while reset is held low.
  always_comb begin
    bus.in_rdy    = reset & in_rdy_raw;
    bus.out_val   = reset & go_raw[p_num_stages-1];
    bus.go        = {p_num_stages{reset}} & go_raw;
    bus.reg_en    = reset ? ~sout[p_num_stages-1:0] : '1;
    bus.val       = val_q;
    bus.occupancy = reset ? occ_q : '0;
  end

endmodule

// File: tb/tb_vc_pipe_ctrl_chain.sv
// Self-checking bench for vc_pipe_ctrl_chain.
// The reference model tracks which stages hold a message and whether that message has
// already used its squash. Every cycle, it works out which messages hold and which
// advance, starting from the output side.
module tb_vc_pipe_ctrl_chain;
  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_pipe_ctrl_chain_if #(.p_num_stages(N), .p_cnt_nbits(CW)) bus ();

  vc_pipe_ctrl_chain #(.p_num_stages(N), .p_cnt_nbits(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  bit m_v[N];
  bit m_fired[N];

  int       cyc = 0;
  int       n_out;
  int       first_out;
  int       first_acc;
  logic     last_out_val;
  logic     last_in_rdy;
  logic [N-1:0] last_val;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle.
  // Inputs are already applied. Outputs are checked at the falling edge, and the
  // model advances after the rising edge.
  task automatic step();
    int           k;
    bit           ahead;
    bit           live;
    bit           hold[N];
    bit           move[N];
    bit           nv[N];
    bit           nf[N];
    logic [N-1:0] e_reg, e_go, e_val;
    logic         e_in, e_out;
    int           e_occ;
    @(negedge clk);
    // The oldest message with an unused squash request kills everything younger.
    k = -1;
    for (int i = N - 1; i >= 0; i--)
      if (k < 0 && m_v[i] && bus.squash_req[i] && !m_fired[i]) k = i;
    ahead = bus.out_rdy;
    for (int i = N - 1; i >= 0; i--) begin
      live    = m_v[i] && !bus.flush && (i >= k);
      hold[i] = live && (bus.stall_req[i] || !ahead);
      move[i] = live && !hold[i];
      ahead   = !hold[i];
    end
    e_in  = ahead && !bus.flush && (k < 0);
    e_out = move[N-1];
    e_occ = 0;
    for (int i = 0; i < N; i++) begin
      e_val[i] = m_v[i];
      e_reg[i] = !hold[i];
      e_go[i]  = move[i];
      e_occ    += int'(m_v[i]);
    end
    if (!reset) begin
      e_in  = 1'b0;
      e_out = 1'b0;
      e_reg = '1;
      e_go  = '0;
      e_occ = 0;
    end
    chk("in_rdy", 32'(bus.in_rdy), 32'(e_in));
    chk("out_val", 32'(bus.out_val), 32'(e_out));
    chk("reg_en", 32'(bus.reg_en), 32'(e_reg));
    chk("go", 32'(bus.go), 32'(e_go));
    chk("val", 32'(bus.val), 32'(e_val));
    chk("occupancy", 32'(bus.occupancy), 32'(e_occ));
    last_out_val = bus.out_val;
    last_in_rdy  = bus.in_rdy;
    last_val     = bus.val;
    if (bus.out_val === 1'b1) begin
      n_out++;
      if (first_out < 0) first_out = cyc;
    end
    if (bus.in_val && bus.in_rdy === 1'b1 && first_acc < 0) first_acc = cyc;
    for (int i = N - 1; i >= 0; i--) begin
      nv[i] = 1'b0;
      nf[i] = 1'b0;
      if (hold[i]) begin
        nv[i] = 1'b1;
        nf[i] = m_fired[i] || (i == k);
      end else if (i > 0 && move[i > 0 ? i - 1 : 0]) begin
        nv[i] = 1'b1;
      end else if (i == 0 && bus.in_val && e_in) begin
        nv[i] = 1'b1;
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      m_v[i]     = reset ? nv[i] : 1'b0;
      m_fired[i] = reset ? nf[i] : 1'b0;
    end
    #1;
    cyc++;
  endtask

  initial begin
    reset          = 1'b0;
    bus.in_val     = 1'b0;
    bus.out_rdy    = 1'b0;
    bus.stall_req  = '0;
    bus.squash_req = '0;
    bus.flush      = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_v[i]     = 1'b0;
      m_fired[i] = 1'b0;
    end
    n_out     = 0;
    first_out = -1;
    first_acc = -1;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b1;

    // Streaming with no requests.
    bus.in_val  = 1'b1;
    bus.out_rdy = 1'b1;
    n_out       = 0;
    first_out   = -1;
    first_acc   = -1;
    repeat (17) step();
    chk("p1_latency", 32'(first_out - first_acc), 32'd4);
    chk("p1_count", 32'(n_out), 32'd13);

    // Consumer back-pressure on a full pipe.
    bus.out_rdy = 1'b0;
    repeat (3) step();
    chk("p2_full", 32'(last_val), 32'hf);
    bus.out_rdy = 1'b1;
    repeat (4) step();

    // Stage 1 stalls; stage 2 drains into a bubble.
    bus.stall_req = 4'b0010;
    repeat (2) step();
    bus.stall_req = '0;
    repeat (4) step();

    // Stalled squasher holding its request.
    bus.stall_req  = 4'b0100;
    bus.squash_req = 4'b0100;
    repeat (3) step();
    bus.stall_req  = '0;
    bus.squash_req = '0;
    repeat (6) step();

    // Flush together with a squash from the oldest stage.
    bus.flush      = 1'b1;
    bus.squash_req = 4'b1000;
    step();
    chk("p5_out_val", 32'(last_out_val), 32'd0);
    bus.flush      = 1'b0;
    bus.squash_req = '0;
    bus.in_val     = 1'b0;
    step();
    chk("p5_val", 32'(last_val), 32'd0);

    // Reset arriving mid-stream with val=1011.
    bus.in_val = 1'b1;
    repeat (5) step();
    bus.stall_req = 4'b0010;
    step();
    bus.stall_req = '0;
    reset         = 1'b0;
    step();
    chk("p6_pre_reset", 32'(last_val), 32'hb);
    step();
    chk("p6_val", 32'(last_val), 32'd0);
    chk("p6_in_rdy", 32'(last_in_rdy), 32'd0);
    reset = 1'b1;
    repeat (8) step();

    // Randomized traffic.
    repeat (400) begin
      bus.in_val  = ($urandom_range(0, 3) != 0);
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        bus.stall_req[i]  = ($urandom_range(0, 7) == 0);
        bus.squash_req[i] = ($urandom_range(0, 9) == 0);
      end
      bus.flush = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_pipe_ctrl_chain.md
Name: vc_pipe_ctrl_chain

Overview:
Centralised valid/stall/squash control for a linear pipeline of p_num_stages stages, replacing per-stage control instances wired in a chain. It sits between a val/rdy producer and a val/rdy consumer and drives per-stage register enables and valid bits for an external datapath. Stage datapaths supply per-stage stall and squash requests. Beyond the single-stage controller, it adds:
- one-shot squash semantics
- a global flush
- an occupancy count

Parameters:
p_num_stages, 4, number of pipeline stages (1..16); stage 0 is youngest (input side), stage N-1 is oldest (output side)
p_cnt_nbits, 3, width of occupancy count; must satisfy 2^p_cnt_nbits > p_num_stages

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (asserted when 0)
in_val  input  1  producer has a message
in_rdy  output  1  controller accepts a message into stage 0 this cycle
out_val  output  1  stage N-1 holds a finished message
out_rdy  input  1  consumer accepts
stall_req  input  N  per-stage stall request from the stage datapath
squash_req  input  N  per-stage request to kill all younger stages
flush  input  1  kill every stage and block input this cycle
reg_en  output  N  per-stage pipeline register enable
val  output  N  per-stage registered valid bit (val_q)
go  output  N  stage i passes a live message onward this cycle
occupancy  output  p_cnt_nbits  number of valid stages

Behaviour:
- Reset (reset==0 at posedge):
  - val_q=0 and sq_done_q=0 next cycle.
  - Outputs during reset cycles: in_rdy=0; out_val=0; reg_en=all-ones; go=0; occupancy=0.
  - Reset mid-operation discards all in-flight messages.
- Combinational terms, for i in 0..N-1:
  - cs[i] = val_q[i] & squash_req[i] & ~sq_done_q[i]. Squash fires once per resident message.
  - kill[i] = flush | OR(cs[j], j>i). Squash by stage k kills stages <k; stage k itself survives.
  - st[i] = val_q[i] & stall_req[i].
  - sout[N] = ~out_rdy.
  - sout[i] = val_q[i] & ~kill[i] & (st[i] | sout[i+1]).
  - go[i] = val_q[i] & ~kill[i] & ~st[i] & ~sout[i+1].
  - reg_en[i] = ~sout[i].
  - in_rdy = ~sout[0] & ~flush & ~OR(cs).
  - out_val = go[N-1].
- Sequential, when not reset:
  - val_q[0] <= reg_en[0] ? (in_val & in_rdy) : val_q[0].
  - val_q[i>0] <= reg_en[i] ? go[i-1] : val_q[i].
  - A killed stage is never stalled, so it reloads with 0 from an upstream stage that is also killed.
  - sq_done_q[i] <= reg_en[i] ? 0 : (sq_done_q[i] | cs[i]).
- Stalled squasher: a stage asserting squash_req while stalled kills younger stages exactly once. Younger stages refill normally while it remains stalled; a held squash_req does not re-fire.
- Flush: all val_q cleared next cycle; no message leaves (out_val=0 while flush=1). Flush wins over any simultaneous stall or squash.
- Combined: a simultaneous squash in stages j<k is subsumed by k's kill; stage j is killed, so its cs is discarded.
- occupancy: registered popcount of next val_q; equals popcount(val_q) every cycle; max p_num_stages.
- Latency: with no stalls, in_val&in_rdy at cycle t gives out_val at t+N. Throughput is 1 message/cycle.
- Back-pressure: out_rdy=0 with a full pipe gives in_rdy=0 in the same cycle (combinational ripple, no bubble). Bubbles collapse: a stage with val_q=0 never stalls upstream.
- No combinational path from in_val to in_rdy. out_rdy to in_rdy is combinational by design.

Test Plan:
- N=4, in_val=1 every cycle, out_rdy=1, no requests → first out_val at cycle 4 after first accept; 13 messages out in order over 13 consecutive cycles; occupancy saturates at 4.
- Full pipe, out_rdy=0 for 3 cycles → in_rdy=0 and reg_en=4'b0000 those 3 cycles; val stays 4'b1111; no loss or duplication after out_rdy returns to 1.
- stall_req[1]=1 for 2 cycles, pipe full → reg_en=4'b1100; stage 2 drains leaving val[2]=0 (bubble); stages 0–1 hold; resumes with no lost messages.
- squash_req[2] held 3 cycles while stage 2 is stalled → val[1:0] cleared after first cycle only; in_rdy=0 that cycle; later arrivals in stages 0–1 survive; stage-2 message eventually exits.
- flush=1 together with squash_req[3]=1 and out_rdy=1, pipe full → out_val=0; val=0 and occupancy=0 next cycle.
- reset driven low mid-stream with val=4'b1011 → val=0, in_rdy=0, out_val=0 next cycle; normal operation resumes one cycle after reset returns high.
